// File: rtl/usb_rxsync.sv
// usb_rxsync: USB receive synchronizer with bit-centre strobe recovery at 4x full-speed rate.
// Define USB_RXSYNC_SE0FILT_EN to report SE0 only after it is seen on two consecutive strobes.
module usb_rxsync #(
  parameter int SYNC_STAGES = 2,
  parameter int LS_DIV      = 8
) (
  input  logic       clk_4xrate,
  input  logic       rst1_async,
  input  logic       speed,
  input  logic       drx,
  input  logic       drx_plus,
  input  logic       drx_minus,
  output logic       rx_strobe,
  output logic       rx_bit,
  output logic       rx_se0,
  output logic [1:0] line_state,
  output logic       rx_edge
);
  localparam int PW = $clog2(4 * LS_DIV);
  localparam logic [PW-1:0] FS_LAST = PW'(3);
  localparam logic [PW-1:0] LS_LAST = PW'(4 * LS_DIV - 1);
  localparam logic [PW-1:0] FS_HALF = PW'(2);
  localparam logic [PW-1:0] LS_HALF = PW'(2 * LS_DIV);
  logic [SYNC_STAGES-1:0] sync_d, sync_p, sync_m;
  logic          d, p, m, hist, speed_q, spd_vld, spd_chg, se0, se0_hold;
  logic [PW-1:0] phase, phase_nxt, last, half;
  logic [1:0]    ls_now;
  assign d = sync_d[SYNC_STAGES-1];
  assign p = sync_p[SYNC_STAGES-1];
  assign m = sync_m[SYNC_STAGES-1];
  always_ff @(posedge clk_4xrate or posedge rst1_async) begin
    if (rst1_async) begin
      sync_d  <= '0;
      sync_p  <= '0;
      sync_m  <= '0;
      hist    <= 1'b0;
      speed_q <= 1'b0;
      spd_vld <= 1'b0;
      phase   <= '0;
    end else begin
      sync_d  <= {sync_d[SYNC_STAGES-2:0], drx};
      sync_p  <= {sync_p[SYNC_STAGES-2:0], drx_plus};
      sync_m  <= {sync_m[SYNC_STAGES-2:0], drx_minus};
      hist    <= d;
      speed_q <= speed;
      spd_vld <= 1'b1;
      phase   <= phase_nxt;
    end
  end
  // spd_vld masks the unknown pre-reset speed so release never looks like a speed change
  always_comb begin
    last      = speed ? FS_LAST : LS_LAST;
    half      = speed ? FS_HALF : LS_HALF;
    rx_edge   = d ^ hist;
    spd_chg   = spd_vld & (speed ^ speed_q);
    rx_strobe = phase == half;
    phase_nxt = spd_chg ? '0 : rx_edge ? PW'(1) : (phase >= last) ? '0 : phase + 1'b1;
    se0       = ~p & ~m;
    ls_now    = (speed | (p == m)) ? {m, p} : {p, m};
  end
`ifdef USB_RXSYNC_SE0FILT_EN
  logic se0_prev;
  always_ff @(posedge clk_4xrate or posedge rst1_async) begin
    if (rst1_async) se0_prev <= 1'b0;
    else if (rx_strobe) se0_prev <= se0;
  end
  assign se0_hold = se0 & ~se0_prev;
`else
  assign se0_hold = 1'b0;
`endif
  // a first-seen SE0 under filtering keeps the previous line state
  always_ff @(posedge clk_4xrate or posedge rst1_async) begin
    if (rst1_async) begin
      rx_bit     <= 1'b0;
      rx_se0     <= 1'b0;
      line_state <= 2'b00;
    end else if (rx_strobe) begin
      rx_bit     <= d;
      rx_se0     <= se0 & ~se0_hold;
      line_state <= se0_hold ? line_state : ls_now;
    end
  end
endmodule

// File: tb/tb_usb_rxsync.sv
// tb_usb_rxsync: randomized scoreboard bench for usb_rxsync using an anchor-based timing model.
module tb_usb_rxsync;
  localparam int S = 2, LSD = 8, N = 8192;
  logic clk = 1'b0, rst = 1'b1, speed = 1'b1, drx = 1'b0, dp = 1'b0, dm = 1'b0;
  logic rx_strobe, rx_bit, rx_se0, rx_edge;
  logic [1:0] line_state;
  usb_rxsync #(.SYNC_STAGES(S), .LS_DIV(LSD)) dut (
    .clk_4xrate(clk), .rst1_async(rst), .speed(speed), .drx(drx), .drx_plus(dp),
    .drx_minus(dm), .rx_strobe(rx_strobe), .rx_bit(rx_bit), .rx_se0(rx_se0),
    .line_state(line_state), .rx_edge(rx_edge)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int         c;
    logic       b;
    logic       se0;
    logic [1:0] ls;
  } exp_t;
  exp_t sq[$];
  int   eq[$];
  logic ud[N], up[N], um[N], us[N];
  int   rel = 0, anchor = 0, checks = 0, fails = 0;
  bit   in_rst = 1'b1;
  logic [1:0] ls_hold = 2'b00;
`ifdef USB_RXSYNC_SE0FILT_EN
  logic se0_last = 1'b0;
`endif
  // a pin value reaches the logic S cycles after it is driven, and only from bits driven after release
  function automatic logic sync_of(int which, int c);
    int k = c - S;
    if (k < rel) return 1'b0;
    return which == 0 ? ud[k] : which == 1 ? up[k] : um[k];
  endfunction
  function automatic int per(logic s);
    return s ? 4 : 4 * LSD;
  endfunction
  // phase is the distance from the most recent zero point (release, edge, speed change) modulo the period
  task automatic model(int c);
    int ph;
    logic sd, sp, sm, hd, se0;
    logic [1:0] ls;
    if (rst) begin
      in_rst = 1'b1;
      return;
    end
    if (in_rst) begin
      in_rst = 1'b0; rel = c; anchor = c; ls_hold = 2'b00;
`ifdef USB_RXSYNC_SE0FILT_EN
      se0_last = 1'b0;
`endif
    end
    sd = sync_of(0, c); sp = sync_of(1, c); sm = sync_of(2, c); hd = sync_of(0, c - 1);
    ph = (c == anchor) ? 0 : (c - anchor) % per(us[c-1]);
    if (ph == per(us[c]) / 2) begin
      se0 = !sp && !sm;
      ls  = (us[c] || sm == sp) ? {sm, sp} : {sp, sm};
`ifdef USB_RXSYNC_SE0FILT_EN
      if (se0 && !se0_last) begin
        se0_last = 1'b1; se0 = 1'b0; ls = ls_hold;
      end else se0_last = se0;
`endif
      ls_hold = ls;
      sq.push_back('{c, sd, se0, ls});
    end
    if (sd != hd) begin
      eq.push_back(c);
      anchor = c;
    end
    if (c > rel && us[c] != us[c-1]) anchor = c + 1;
  endtask
  task automatic step(logic d, logic p, logic m, logic s, logic r);
    @(posedge clk);
    #1;
    if (cyc >= N - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, N - 1);
      $fatal(1, "cycle budget exhausted");
    end
    drx = d; dp = p; dm = m; speed = s; rst = r;
    ud[cyc] = d; up[cyc] = p; um[cyc] = m; us[cyc] = s;
    model(cyc);
  endtask
  task automatic lvl(logic v, int len, logic s);
    repeat (len) step(v, v, !v, s, 1'b0);
  endtask
  task automatic se0_for(int len, logic s);
    repeat (len) step(1'b0, 1'b0, 1'b0, s, 1'b0);
  endtask
  task automatic rand_bits(int n, logic s, int jit);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0) se0_for(per(s), s);
      else lvl(1'($urandom), per(s) - jit + int'($urandom_range(0, 2 * jit)), s);
    end
  endtask
  exp_t pe;
  bit   pend = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ({rx_strobe, rx_edge, rx_bit, rx_se0, line_state} !== 6'b0) begin
        fails++;
        $display("FAIL reset_clear cyc=%0d got strobe=%b edge=%b bit=%b se0=%b ls=%b want all 0",
                 cyc, rx_strobe, rx_edge, rx_bit, rx_se0, line_state);
      end
      pend = 1'b0;
    end else begin
      if (pend) begin
        checks++;
        if ({rx_bit, rx_se0, line_state} !== {pe.b, pe.se0, pe.ls}) begin
          fails++;
          $display("FAIL sample strobe_cyc=%0d got bit=%b se0=%b ls=%b want bit=%b se0=%b ls=%b",
                   pe.c, rx_bit, rx_se0, line_state, pe.b, pe.se0, pe.ls);
        end
        pend = 1'b0;
      end
      if (rx_edge) begin
        checks++;
        if (eq.size() == 0) begin
          fails++;
          $display("FAIL edge_unexpected got cyc=%0d want none", cyc);
        end else begin
          if (eq[0] != cyc) begin
            fails++;
            $display("FAIL edge_time got cyc=%0d want cyc=%0d", cyc, eq[0]);
          end
          void'(eq.pop_front());
        end
      end
      if (rx_strobe) begin
        checks++;
        if (sq.size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected got cyc=%0d want none", cyc);
        end else begin
          pe = sq.pop_front();
          if (pe.c != cyc) begin
            fails++;
            $display("FAIL strobe_time got cyc=%0d want cyc=%0d", cyc, pe.c);
          end
          pend = 1'b1;
        end
      end
    end
  end
  initial begin
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    lvl(1'b1, 12, 1'b1);
    lvl(1'b0, 12, 1'b1);
    rand_bits(40, 1'b1, 1);
    for (int i = 0; i < 8; i++) lvl(1'(i), 5, 1'b1);
    lvl(1'b1, 30, 1'b1);
    se0_for(4, 1'b1);
    lvl(1'b1, 12, 1'b1);
    se0_for(8, 1'b1);
    lvl(1'b1, 14, 1'b1);
    lvl(1'b0, 2, 1'b1);
    lvl(1'b0, 40, 1'b0);
    for (int i = 0; i < 6; i++) lvl(1'(i), 32, 1'b0);
    se0_for(32, 1'b0);
    lvl(1'b1, 40, 1'b0);
    se0_for(64, 1'b0);
    lvl(1'b1, 40, 1'b0);
    rand_bits(8, 1'b0, 2);
    lvl(1'b1, 7, 1'b0);
    lvl(1'b1, 9, 1'b1);
    rand_bits(20, 1'b1, 1);
    lvl(1'b0, 1, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    lvl(1'b0, 3, 1'b1);
    rand_bits(30, 1'b1, 1);
    for (int k = 0; k < 4; k++) begin
      logic s = 1'($urandom);
      lvl(1'($urandom), 5, s);
      rand_bits(s ? 25 : 5, s, s ? 1 : 3);
    end
    lvl(1'b1, 20, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sq.size() != 0 || eq.size() != 0) begin
      fails++;
      $display("FAIL leftover got strobes=%0d edges=%0d want 0 0", sq.size(), eq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
